// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: R-type funct codes and FSM states.
package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0] addend_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opnd_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    // The remainder is always below the divisor, so the W-bit subtraction cannot wrap.
    always_comb begin
        sum     = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, addend_i} : '0);
        shifted = {acc_i, opnd_i[WIDTH-1]};
        ge      = (shifted >= {1'b0, addend_i});
        if (mode_i) begin
            acc_o  = ge ? (shifted[WIDTH-1:0] - addend_i) : shifted[WIDTH-1:0];
            opnd_o = {opnd_i[WIDTH-2:0], ge};
        end else begin
            acc_o  = sum[WIDTH:1];
            opnd_o = {sum[0], opnd_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU decode as illegal.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, opnd_q, opnd_d, addend_q, addend_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             negLo_q, negLo_d, done_q, done_d, err_q, err_d;
`ifdef MULDIV_DIV_EN
    logic             div_q, div_d, negHi_q, negHi_d;
`endif

    logic             isMul, isDiv, isSigned, isRead, stepMode;
    logic             signA, signB;
    logic [WIDTH-1:0] absA, absB, stepAcc, stepOpnd;
    logic [2*WIDTH-1:0] prod;

    assign isMul    = (funct == FN_MULT) || (funct == FN_MULTU);
    assign isSigned = (funct == FN_MULT) || (funct == FN_DIV);
    assign isRead   = (funct == FN_MFHI) || (funct == FN_MFLO);
    assign signA    = isSigned && op_a[WIDTH-1];
    assign signB    = isSigned && op_b[WIDTH-1];
    assign absA     = signA ? -op_a : op_a;
    assign absB     = signB ? -op_b : op_b;
    assign prod     = {acc_q, opnd_q};
`ifdef MULDIV_DIV_EN
    assign isDiv    = (funct == FN_DIV) || (funct == FN_DIVU);
    assign stepMode = div_q;
`else
    assign isDiv    = 1'b0;
    assign stepMode = 1'b0;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .addend_i (addend_q),
        .mode_i   (stepMode),
        .acc_o    (stepAcc),
        .opnd_o   (stepOpnd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (isMul || isDiv)) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = done_q;
        err    = err_q;
        hi_out = hi_q;
        lo_out = lo_q;
        result = (funct == FN_MFHI) ? hi_q : ((funct == FN_MFLO) ? lo_q : '0);
    end

    // Operands enter as magnitudes; FIX restores signs. A zero divisor keeps LO all ones.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        addend_d = addend_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        negLo_d  = negLo_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d    = div_q;
        negHi_d  = negHi_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (isMul || isDiv) begin
                        cnt_d    = '0;
                        acc_d    = '0;
                        negLo_d  = signA ^ signB;
                        opnd_d   = isMul ? absB : absA;
                        addend_d = isMul ? absA : absB;
`ifdef MULDIV_DIV_EN
                        div_d    = isDiv;
                        negHi_d  = signA;
                        if (isDiv && (op_b == '0)) negLo_d = 1'b0;
`endif
                    end else if (funct == FN_MTHI) begin
                        hi_d = op_a;
                    end else if (funct == FN_MTLO) begin
                        lo_d = op_a;
                    end else if (!isRead) begin
                        err_d = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d  = stepAcc;
                opnd_d = stepOpnd;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            FIX: begin
                done_d = 1'b1;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    lo_d = negLo_q ? -opnd_q : opnd_q;
                    hi_d = negHi_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = negLo_q ? -prod : prod;
                end
`else
                {hi_d, lo_d} = negLo_q ? -prod : prod;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            addend_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            negLo_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q    <= 1'b0;
            negHi_q  <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            addend_q <= addend_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            negLo_q  <= negLo_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef MULDIV_DIV_EN
            div_q    <= div_d;
            negHi_q  <= negHi_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32); division cases follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_BAD   = 6'b101010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'b0;
    logic [31:0] op_a  = '0;
    logic [31:0] op_b  = '0;
    logic        busy, done, err;
    logic [31:0] result, hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    int cyc, bcyc;

    muldiv_unit dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .funct  (funct),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clock = ~clock;

    // Caller is at a negedge; the request is accepted at the following posedge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; funct = f; op_a = a; op_b = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busyCycles);
        cycles = 0; busyCycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy === 1'b1) busyCycles++;
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_err: got %b%b want 00", done, err); end
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_hilo: got %h %h want 0 0", hi_out, lo_out); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mult;
        issue(F_MULT, 32'hFFFFFFFD, 32'd5);
        waitDone(cyc, bcyc);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL mult_latency: got %0d want 33", cyc); end
        checks++; if (bcyc !== 33) begin errors++; $display("[TB] FAIL mult_busy_cycles: got %0d want 33", bcyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mult_busy_at_done: got %b want 0", busy); end
        checks++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h want ffffffff", hi_out); end
        checks++; if (lo_out !== 32'hFFFFFFF1) begin errors++; $display("[TB] FAIL mult_lo: got %h want fffffff1", lo_out); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse: got %b want 0", done); end
        issue(F_MULT, 32'hFFFFFFF9, 32'hFFFFFFFA);
        waitDone(cyc, bcyc);
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h2A) begin errors++; $display("[TB] FAIL mult_negneg: got %h %h want 0 2a", hi_out, lo_out); end
        issue(F_MULT, 32'h80000000, 32'd2);
        waitDone(cyc, bcyc);
        checks++; if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'h0) begin errors++; $display("[TB] FAIL mult_minint: got %h %h want ffffffff 0", hi_out, lo_out); end
    endtask

    task automatic test_multu_reads;
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(cyc, bcyc);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL multu_latency: got %0d want 33", cyc); end
        checks++; if (hi_out !== 32'hFFFFFFFE || lo_out !== 32'h1) begin errors++; $display("[TB] FAIL multu_hilo: got %h %h want fffffffe 1", hi_out, lo_out); end
        @(negedge clock);
        funct = F_MFHI; #1;
        checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mfhi_result: got %h want fffffffe", result); end
        funct = F_MFLO; #1;
        checks++; if (result !== 32'h1) begin errors++; $display("[TB] FAIL mflo_result: got %h want 1", result); end
        funct = F_MULT; #1;
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL other_result: got %h want 0", result); end
        @(negedge clock);
    endtask

    task automatic test_mthi_idle;
        issue(F_MTHI, 32'h1234, 32'h0);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mthi_flags: got busy %b done %b want 0 0", busy, done); end
        funct = F_MFHI; #1;
        checks++; if (result !== 32'h1234) begin errors++; $display("[TB] FAIL mthi_mfhi: got %h want 1234", result); end
        @(negedge clock);
        issue(F_MTLO, 32'hCAFE, 32'h0);
        funct = F_MFLO; #1;
        checks++; if (result !== 32'hCAFE) begin errors++; $display("[TB] FAIL mtlo_mflo: got %h want cafe", result); end
        @(negedge clock);
    endtask

    task automatic test_illegal;
        issue(F_BAD, 32'h5555, 32'h6666);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err: got err %b busy %b want 1 0", err, busy); end
        checks++; if (hi_out !== 32'h1234 || lo_out !== 32'hCAFE) begin errors++; $display("[TB] FAIL illegal_hilo: got %h %h want 1234 cafe", hi_out, lo_out); end
        @(negedge clock);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err_pulse: got %b want 0", err); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        issue(F_DIV, 32'hFFFFFFF9, 32'd2);
        waitDone(cyc, bcyc);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL div_latency: got %0d want 33", cyc); end
        checks++; if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg: got %h %h want ffffffff fffffffd", hi_out, lo_out); end
        issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitDone(cyc, bcyc);
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h80000000) begin errors++; $display("[TB] FAIL div_overflow: got %h %h want 0 80000000", hi_out, lo_out); end
        issue(F_DIVU, 32'd100, 32'd7);
        waitDone(cyc, bcyc);
        checks++; if (hi_out !== 32'd2 || lo_out !== 32'd14) begin errors++; $display("[TB] FAIL divu_basic: got %h %h want 2 e", hi_out, lo_out); end
    endtask
`endif

    task automatic test_divzero;
`ifdef MULDIV_DIV_EN
        issue(F_DIVU, 32'd7, 32'd0);
        waitDone(cyc, bcyc);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL divzero_latency: got %0d want 33", cyc); end
        checks++; if (hi_out !== 32'd7 || lo_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu_zero: got %h %h want 7 ffffffff", hi_out, lo_out); end
        issue(F_DIV, 32'hFFFFFFF9, 32'd0);
        waitDone(cyc, bcyc);
        checks++; if (hi_out !== 32'hFFFFFFF9 || lo_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_zero_neg: got %h %h want fffffff9 ffffffff", hi_out, lo_out); end
`else
        issue(F_DIVU, 32'd7, 32'd0);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL nodiv_err: got err %b busy %b want 1 0", err, busy); end
        @(negedge clock);
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL nodiv_pulse: got err %b busy %b want 0 0", err, busy); end
        checks++; if (hi_out !== 32'h1234 || lo_out !== 32'hCAFE) begin errors++; $display("[TB] FAIL nodiv_hilo: got %h %h want 1234 cafe", hi_out, lo_out); end
`endif
        @(negedge clock);
    endtask

    task automatic test_busy_ignored;
        issue(F_MULT, 32'd6, 32'd7);
        issue(F_MTHI, 32'h1234, 32'h0);
        issue(F_BAD, 32'h0, 32'h0);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL busy_no_err: got %b want 0", err); end
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(cyc, bcyc);
        checks++; if (cyc !== 30) begin errors++; $display("[TB] FAIL busy_latency: got %0d want 30", cyc); end
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'd42) begin errors++; $display("[TB] FAIL busy_ignored: got %h %h want 0 2a", hi_out, lo_out); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        issue(F_MULTU, 32'd3, 32'd4);
        waitDone(cyc, bcyc);
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'd12) begin errors++; $display("[TB] FAIL b2b_first: got %h %h want 0 c", hi_out, lo_out); end
        issue(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got busy %b done %b want 1 0", busy, done); end
        waitDone(cyc, bcyc);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 33", cyc); end
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h1) begin errors++; $display("[TB] FAIL b2b_second: got %h %h want 0 1", hi_out, lo_out); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_op;
        issue(F_MTHI, 32'h55, 32'h0);
        issue(F_MTLO, 32'hAA, 32'h0);
        issue(F_MULT, 32'd9, 32'd9);
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b%b%b want 000", busy, done, err); end
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_hilo: got %h %h want 0 0", hi_out, lo_out); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(F_MULT, 32'hFFFFFFF7, 32'd9);
        waitDone(cyc, bcyc);
        checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL rst_after_latency: got %0d want 33", cyc); end
        checks++; if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFAF) begin errors++; $display("[TB] FAIL rst_after_mult: got %h %h want ffffffff ffffffaf", hi_out, lo_out); end
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu_reads;
        test_mthi_idle;
        test_illegal;
`ifdef MULDIV_DIV_EN
        test_div;
`endif
        test_divzero;
        test_busy_ignored;
        test_back_to_back;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with HI/LO registers, parametrised in operand width; the sequential successor to the combinational ALU control decoder. It decodes R-type funct codes for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO, and runs iterative shift-add multiplication and restoring division. It sits beside the ALU in the execute stage. The main control unit stalls on `busy` and reads `result` for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width, and the width of each of HI and LO; must be even and ≥4.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width (derived, not overridden).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request valid; accepted when `start && !busy`.
- `funct`  in  6  R-type funct field.
- `op_a`  in  WIDTH  rs operand (multiplicand or dividend; MTHI/MTLO source).
- `op_b`  in  WIDTH  rt operand (multiplier or divisor).
- `busy`  out  1  high while a MULT/DIV is in flight.
- `done`  out  1  one-cycle pulse after HI/LO update from MULT/DIV.
- `err`  out  1  one-cycle pulse: illegal funct accepted, or a compiled-out op.
- `result`  out  WIDTH  combinational: HI when funct=MFHI, LO when funct=MFLO, else 0.
- `hi_out`, `lo_out`  out  WIDTH  current HI and LO registers.

## Operation
- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- FSM has three states: IDLE, CALC and FIX.
  - IDLE → CALC on an accepted MULT/MULTU/DIV/DIVU. The counter is set to 0.
  - CALC → FIX when the counter reaches WIDTH-1.
  - FIX → IDLE unconditionally.
- `busy` = (state != IDLE).
- Signed operations take absolute values on entry and record the result signs.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Multiplication forms a 2·WIDTH-bit product with one shift-add step per CALC cycle. Result: HI = upper half, LO = lower half.
- Division is restoring, with one quotient bit per CALC cycle. Result: LO = quotient, HI = remainder.
- FIX applies two's-complement negation where the recorded signs require it, then writes HI and LO.
- Divide by zero (b=0), both DIV and DIVU: LO = all ones, HI = op_a unchanged. The full iteration latency is still used.
- Signed overflow (DIV of most-negative value by -1): LO = most-negative value, HI = 0.
- MTHI and MTLO in IDLE write HI or LO at the accept edge. No `done` pulse; `busy` stays low.
- MFHI and MFLO are pure reads with no state change.
- Any other funct with `start` in IDLE: `err` = 1 on the next cycle, with no other effect.
- `start` while `busy`: ignored entirely. No `err`, no register change, and the operands captured at acceptance are unaffected.
- `result` shows the HI/LO value at its last committed update. It is not valid while `busy` for an op in flight; control must stall.

## Timing
- Reset (asynchronous):
  - state = IDLE, counter = 0.
  - HI = LO = 0.
  - `busy` = `done` = `err` = 0.
- Reset mid-operation aborts the operation and leaves HI/LO at 0.
- Sequence for an accepted MULT/DIV at edge E0:
  - `busy` is high from E0 to E(WIDTH+1).
  - CALC covers edges E1..E(WIDTH).
  - FIX commits HI/LO at E(WIDTH+1).
  - `done` is high for one cycle, E(WIDTH+1) to E(WIDTH+2), with `busy` low in that same cycle.
- Latency from accept to `done` visible = WIDTH+1 cycles (33 for WIDTH=32).
- A new `start` may be accepted in the cycle `done` is high.
- MTHI/MTLO take effect at the accept edge, so `result` for a following MFHI reflects them on the next cycle.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: DIV and DIVU are implemented as described above.
- Undefined: the divider datapath is removed. DIV/DIVU are treated as illegal funct codes: `err` pulses, no state change, HI/LO preserved. MULT/MULTU timing is unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - the funct localparams (FN_MFHI … FN_DIVU);
  - the state enum `muldiv_state_t` (IDLE, CALC, FIX).
- One sub-module, `muldiv_step`: a combinational single-iteration datapath, parametrised by WIDTH.
  - Inputs: accumulator/remainder, partial operand, mode (mul/div).
  - Outputs: next accumulator and the shifted operand.
- The top level keeps the FSM, counter, sign flags, HI/LO and the funct decode.

## Test plan
- MULT, a=-3 (0xFFFFFFFD), b=5 → at `done`, HI=0xFFFFFFFF and LO=0xFFFFFFF1. `done` rises exactly 33 cycles after the accept edge, and `busy` is high for 33 cycles.
- MULTU, a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then MFHI gives `result`=0xFFFFFFFE, and MFLO gives `result`=0x00000001.
- DIV 0xFFFFFFF9 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: DIVU 7/0 → LO=0xFFFFFFFF, HI=7. Without `MULDIV_DIV_EN`, the same request gives an `err` pulse and HI/LO unchanged.
- Ignored and illegal requests:
  - MTHI 0x1234 while `busy` → ignored. HI afterwards equals the MULT/DIV result.
  - MTHI 0x1234 in IDLE, then MFHI → `result`=0x1234.
  - funct 101010 with `start` → `err`=1 for one cycle.
- Reset mid-operation: assert `reset` at CALC iteration 10 of a MULT → `busy`, `done` and `err` go to 0 immediately, HI=LO=0, and a MULT issued after release completes normally.
